ldtu_decoder: RTL and testbench



---
 rtl/ldtu_decoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_ldtu_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ldtu_decoder.sv
// ldtu_decoder: unpacks 32-bit LiTE-DTU words into a one-per-clock 13-bit sample stream, throttling input via valid/ready.
// Defining LDTU_FRAME_CHECK_EN builds trailer word-count and frame-number checking; otherwise frame_err is tied low.
module ldtu_decoder #(
    parameter int Nbits_32 = 32,
    parameter int Nbits_12 = 12
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [Nbits_32-1:0] DATA32_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [Nbits_12:0]   sample_out,
    output logic                sample_valid,
    output logic                baseline_flag,
    output logic                frame_end,
    output logic                frame_err,
    output logic                header_err
);

    typedef enum logic [2:0] {
        W_IDLE,
        W_BASE5,
        W_BASEN,
        W_SIG2,
        W_SIG1,
        W_TRAIL,
        W_ERR
    } word_kind_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    function automatic word_kind_t decode_kind(input logic [31:0] w);
        word_kind_t k;
        if (w == 32'hEAAA_AAAA) begin
            k = W_IDLE;
        end else if (w[31:30] == 2'b01) begin
            k = W_BASE5;
        end else if (w[31:28] == 4'b1010) begin
            if ((w[27:24] >= 4'd1) && (w[27:24] <= 4'd4)) begin
                k = W_BASEN;
            end else begin
                k = W_ERR;
            end
        end else if (w[31:26] == 6'b001010) begin
            k = W_SIG2;
        end else if (w[31:26] == 6'b001011) begin
            k = W_SIG1;
        end else if (w[31:28] == 4'b1101) begin
            k = W_TRAIL;
        end else begin
            k = W_ERR;
        end
        return k;
    endfunction

    function automatic logic [2:0] sample_count(input word_kind_t k, input logic [2:0] n);
        logic [2:0] c;
        case (k)
            W_BASE5: c = 3'd5;
            W_BASEN: c = n;
            W_SIG2:  c = 3'd2;
            W_SIG1:  c = 3'd1;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

    // Baseline fields are 6 bits wide, zero-extended with gain flag 0; signal fields pass through.
    function automatic logic [12:0] extract(input logic [29:0] w, input logic [2:0] idx, input logic base);
        logic [12:0] s;
        if (base) begin
            case (idx)
                3'd0:    s = {7'd0, w[5:0]};
                3'd1:    s = {7'd0, w[11:6]};
                3'd2:    s = {7'd0, w[17:12]};
                3'd3:    s = {7'd0, w[23:18]};
                3'd4:    s = {7'd0, w[29:24]};
                default: s = 13'd0;
            endcase
        end else begin
            case (idx)
                3'd0:    s = w[12:0];
                3'd1:    s = w[25:13];
                default: s = 13'd0;
            endcase
        end
        return s;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [29:0] word_r;
    logic [29:0] word_nxt_s;
    logic        base_r;
    logic        base_nxt_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_nxt_s;
    logic [2:0]  left_r;
    logic [2:0]  left_nxt_s;
    logic        emit_s;
    logic [12:0] sample_nxt_s;
    word_kind_t  kind_s;
    logic        is_data_s;
    logic        is_base_s;
    logic [2:0]  count_s;
    logic        accept_s;
    logic        ready_s;

    logic [12:0] sample_out_r;
    logic        sample_valid_r;
    logic        baseline_r;
    logic        frame_end_r;
    logic        header_err_r;

    // Input word classification and handshake qualification.
    always_comb begin
        kind_s    = decode_kind(DATA32_in);
        is_base_s = (kind_s == W_BASE5) || (kind_s == W_BASEN);
        is_data_s = is_base_s || (kind_s == W_SIG2) || (kind_s == W_SIG1);
        count_s   = sample_count(kind_s, DATA32_in[26:24]);
        ready_s   = (!RST) && (state_r == ST_IDLE);
        accept_s  = data_valid && ready_s;
    end

    // Next-state and emission: left_r counts samples still owed after the one on sample_out.
    always_comb begin
        state_nxt_s  = state_r;
        word_nxt_s   = word_r;
        base_nxt_s   = base_r;
        idx_nxt_s    = idx_r;
        left_nxt_s   = left_r;
        emit_s       = 1'b0;
        sample_nxt_s = sample_out_r;
        case (state_r)
            ST_EMIT: begin
                emit_s       = 1'b1;
                sample_nxt_s = extract(word_r, idx_r, base_r);
                idx_nxt_s    = idx_r + 3'd1;
                left_nxt_s   = left_r - 3'd1;
                if (left_r == 3'd1) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            ST_IDLE: begin
                if (accept_s && is_data_s) begin
                    emit_s       = 1'b1;
                    sample_nxt_s = extract(DATA32_in[29:0], 3'd0, is_base_s);
                    word_nxt_s   = DATA32_in[29:0];
                    base_nxt_s   = is_base_s;
                    idx_nxt_s    = 3'd1;
                    left_nxt_s   = count_s - 3'd1;
                    if (count_s > 3'd1) begin
                        state_nxt_s = ST_EMIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, word buffer and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= ST_IDLE;
            word_r         <= 30'd0;
            base_r         <= 1'b0;
            idx_r          <= 3'd0;
            left_r         <= 3'd0;
            sample_out_r   <= 13'd0;
            sample_valid_r <= 1'b0;
            baseline_r     <= 1'b0;
            frame_end_r    <= 1'b0;
            header_err_r   <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            word_r         <= word_nxt_s;
            base_r         <= base_nxt_s;
            idx_r          <= idx_nxt_s;
            left_r         <= left_nxt_s;
            sample_out_r   <= sample_nxt_s;
            sample_valid_r <= emit_s;
            baseline_r     <= emit_s && (state_r == ST_EMIT ? base_r : is_base_s);
            frame_end_r    <= accept_s && (kind_s == W_TRAIL);
            header_err_r   <= accept_s && (kind_s == W_ERR);
        end
    end

`ifdef LDTU_FRAME_CHECK_EN
    logic [7:0] word_cnt_r;
    logic [7:0] exp_frame_r;
    logic       frame_err_r;
    logic       frame_bad_s;

    // Trailer consistency against the local word count and expected frame number.
    always_comb begin
        frame_bad_s = (DATA32_in[19:12] != word_cnt_r) || (DATA32_in[27:20] != exp_frame_r);
    end

    // Counter clears and frame number resynchronizes on every trailer, good or bad.
    always_ff @(posedge CLK) begin
        if (RST) begin
            word_cnt_r  <= 8'd0;
            exp_frame_r <= 8'd0;
            frame_err_r <= 1'b0;
        end else if (accept_s && (kind_s == W_TRAIL)) begin
            word_cnt_r  <= 8'd0;
            exp_frame_r <= DATA32_in[27:20] + 8'd1;
            frame_err_r <= frame_bad_s;
        end else if (accept_s && is_data_s) begin
            word_cnt_r  <= word_cnt_r + 8'd1;
            exp_frame_r <= exp_frame_r;
            frame_err_r <= 1'b0;
        end else begin
            word_cnt_r  <= word_cnt_r;
            exp_frame_r <= exp_frame_r;
            frame_err_r <= 1'b0;
        end
    end

    assign frame_err = frame_err_r;
`else
    assign frame_err = 1'b0;
`endif

    assign data_ready    = ready_s;
    assign sample_out    = sample_out_r;
    assign sample_valid  = sample_valid_r;
    assign baseline_flag = baseline_r;
    assign frame_end     = frame_end_r;
    assign header_err    = header_err_r;

endmodule

// File: tb/tb_ldtu_decoder.sv
// Directed self-checking bench for ldtu_decoder; frame-check expectations follow LDTU_FRAME_CHECK_EN.
module tb_ldtu_decoder;

    logic        CLK;
    logic        RST;
    logic [31:0] DATA32_in;
    logic        data_valid;
    logic        data_ready;
    logic [12:0] sample_out;
    logic        sample_valid;
    logic        baseline_flag;
    logic        frame_end;
    logic        frame_err;
    logic        header_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LDTU_FRAME_CHECK_EN
    localparam logic FC = 1'b1;
`else
    localparam logic FC = 1'b0;
`endif

    ldtu_decoder dut (
        .CLK          (CLK),
        .RST          (RST),
        .DATA32_in    (DATA32_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .baseline_flag(baseline_flag),
        .frame_end    (frame_end),
        .frame_err    (frame_err),
        .header_err   (header_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic sv, input logic [12:0] so,
                           input logic bf, input logic rdy);
        chk({tag, ".sample_valid"}, {31'd0, sample_valid}, {31'd0, sv});
        chk({tag, ".sample_out"}, {19'd0, sample_out}, {19'd0, so});
        chk({tag, ".baseline_flag"}, {31'd0, baseline_flag}, {31'd0, bf});
        chk({tag, ".data_ready"}, {31'd0, data_ready}, {31'd0, rdy});
    endtask

    task automatic chk_flags(input string tag, input logic fe, input logic ferr, input logic herr);
        chk({tag, ".frame_end"}, {31'd0, frame_end}, {31'd0, fe});
        chk({tag, ".frame_err"}, {31'd0, frame_err}, {31'd0, ferr});
        chk({tag, ".header_err"}, {31'd0, header_err}, {31'd0, herr});
    endtask

    initial begin
        RST        = 1'b1;
        DATA32_in  = 32'd0;
        data_valid = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 13'h000, 1'b0, 1'b0);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, data_ready}, 32'd1);

        // Five baseline samples of 63
        DATA32_in  = 32'h7FFF_FFFF;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            chk_out($sformatf("base5_s%0d", k), 1'b1, 13'h03F, 1'b1, (k == 4));
        end
        tick();
        chk_out("base5_after", 1'b0, 13'h03F, 1'b0, 1'b1);

        // Back-to-back two-sample signal words, data_valid held through the stall
        DATA32_in  = 32'h2824_7ABC;
        data_valid = 1'b1;
        tick();
        DATA32_in = 32'h2A00_0FFF;
        chk_out("sig_a0", 1'b1, 13'h1ABC, 1'b0, 1'b0);
        tick();
        chk_out("sig_a1", 1'b1, 13'h0123, 1'b0, 1'b1);
        tick();
        data_valid = 1'b0;
        chk_out("sig_b0", 1'b1, 13'h0FFF, 1'b0, 1'b0);
        tick();
        chk_out("sig_b1", 1'b1, 13'h1000, 1'b0, 1'b1);
        tick();
        chk_out("sig_after", 1'b0, 13'h1000, 1'b0, 1'b1);

        // Idle word produces nothing, then a two-sample short baseline word
        DATA32_in  = 32'hEAAA_AAAA;
        data_valid = 1'b1;
        tick();
        chk_out("idle_word", 1'b0, 13'h1000, 1'b0, 1'b1);
        chk_flags("idle_word", 1'b0, 1'b0, 1'b0);
        DATA32_in = 32'hA200_0FC1;
        tick();
        data_valid = 1'b0;
        chk_out("basen_s0", 1'b1, 13'h001, 1'b1, 1'b0);
        tick();
        chk_out("basen_s1", 1'b1, 13'h03F, 1'b1, 1'b1);
        tick();
        chk_out("basen_after", 1'b0, 13'h03F, 1'b0, 1'b1);

        // Unknown header
        DATA32_in  = 32'hF000_0000;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk_out("hdr_err", 1'b0, 13'h03F, 1'b0, 1'b1);
        chk_flags("hdr_err", 1'b0, 1'b0, 1'b1);
        tick();
        chk_flags("hdr_err_clear", 1'b0, 1'b0, 1'b0);

        // Trailers: 4 data words so far, frame 0 expected
        DATA32_in  = 32'hD000_4000;
        data_valid = 1'b1;
        tick();
        chk_flags("trl_f0c4", 1'b1, 1'b0, 1'b0);
        chk("trl_f0c4.sample_valid", {31'd0, sample_valid}, 32'd0);
        DATA32_in = 32'hD050_0000;
        tick();
        chk_flags("trl_f5c0", 1'b1, FC, 1'b0);
        DATA32_in = 32'hD060_0000;
        tick();
        data_valid = 1'b0;
        chk_flags("trl_f6c0", 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("trl_clear", 1'b0, 1'b0, 1'b0);

        // Trailer accepted while the last sample of a one-sample word is on the output
        DATA32_in  = 32'h2C00_1555;
        data_valid = 1'b1;
        tick();
        chk_out("sig1_s0", 1'b1, 13'h1555, 1'b0, 1'b1);
        DATA32_in = 32'hD070_1000;
        tick();
        data_valid = 1'b0;
        chk_out("trl_after_sig1", 1'b0, 13'h1555, 1'b0, 1'b1);
        chk_flags("trl_f7c1", 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a five-sample word
        DATA32_in  = 32'h5555_5555;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk_out("rst_mid_s0", 1'b1, 13'h015, 1'b1, 1'b0);
        tick();
        chk_out("rst_mid_s1", 1'b1, 13'h015, 1'b1, 1'b0);
        RST = 1'b1;
        tick();
        chk_out("rst_mid_t3", 1'b0, 13'h000, 1'b0, 1'b0);
        chk_flags("rst_mid_t3", 1'b0, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, data_ready}, 32'd1);
        tick();
        chk_out("rst_mid_release", 1'b0, 13'h000, 1'b0, 1'b1);
        tick();
        chk_out("rst_mid_quiet", 1'b0, 13'h000, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
